// File: rtl/clkdiv_pkg.sv
// Shared types and divisor clamp for the multi-channel clock divider.
package clkdiv_pkg;

  typedef enum logic {SQUARE = 1'b0, PULSE = 1'b1} clkdiv_mode_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} clkdiv_state_e;

  localparam int MIN_DIV = 2;

  // Divisors below MIN_DIV cannot produce a valid period and are raised to it.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: phase counter, shadow config, IDLE/RUN FSM, output flops.
// Shadow config is applied only at a period boundary or when idle.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clock_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             clock_out,
  output logic             tick,
  output logic             cfg_pending
);

  clkdiv_state_e    state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic [CNT_W-1:0] div_act, div_sh, div_use, div_sh_nx;
  clkdiv_mode_e     mode_act, mode_sh, mode_use, mode_sh_nx;
  logic             pend, pend_nx;
  logic             clk_q, clk_nx, tick_q, tick_nx;
  logic [CNT_W-1:0] n_old, n_use;
  logic [CNT_W:0]   half;
  logic             wrap, apply;

  always_comb begin
    n_old    = CNT_W'(eff_div(32'(div_act)));
    wrap     = (cnt == (n_old - 1'b1));
    apply    = pend && ((state == ST_IDLE) || wrap);
    // The incoming config already governs the output computed on the apply edge.
    div_use  = apply ? div_sh : div_act;
    mode_use = apply ? mode_sh : mode_act;
    n_use    = CNT_W'(eff_div(32'(div_use)));
    half     = ({1'b0, n_use} + (CNT_W+1)'(1)) >> 1;
    cnt_inc  = wrap ? '0 : cnt + 1'b1;

    state_nx = state;
    cnt_nx   = '0;
    clk_nx   = 1'b0;
    tick_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_nx = ST_RUN;
          clk_nx   = 1'b1;
          tick_nx  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_nx = ST_IDLE;
        end else begin
          cnt_nx  = cnt_inc;
          tick_nx = (cnt_inc == '0);
          clk_nx  = (mode_use == PULSE) ? (cnt_inc == '0) : ({1'b0, cnt_inc} < half);
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // A write on the apply edge lands in the shadow and stays pending.
    div_sh_nx  = cfg_we ? cfg_div : div_sh;
    mode_sh_nx = cfg_we ? clkdiv_mode_e'(cfg_mode) : mode_sh;
    pend_nx    = cfg_we ? 1'b1 : (apply ? 1'b0 : pend);
  end

  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      div_act  <= CNT_W'(DEFAULT_DIV);
      div_sh   <= CNT_W'(DEFAULT_DIV);
      mode_act <= SQUARE;
      mode_sh  <= SQUARE;
      pend     <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      div_act  <= div_use;
      div_sh   <= div_sh_nx;
      mode_act <= mode_use;
      mode_sh  <= mode_sh_nx;
      pend     <= pend_nx;
      clk_q    <= clk_nx;
      tick_q   <= tick_nx;
    end
  end

  assign clock_out   = clk_q;
  assign tick        = tick_q;
  assign cfg_pending = pend;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider; decodes the shared config bus
// into per-channel write strobes. Out-of-range channel writes are dropped.
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_en;
    assign wr_en = cfg_we && (32'(cfg_ch) == i);

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock_in    (clock_in),
      .rst         (rst),
      .en          (en[i]),
      .cfg_we      (wr_en),
      .cfg_div     (cfg_div),
      .cfg_mode    (cfg_mode),
      .clock_out   (clock_out[i]),
      .tick        (tick[i]),
      .cfg_pending (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi with three channels.
module tb_clock_divider_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;

  logic              clock_in;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic [NUM_CH-1:0] clock_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] cfg_pending;

  int n_tests = 0;
  int n_fail  = 0;

  clock_divider_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (2)
  ) dut (
    .clock_in    (clock_in),
    .rst         (rst),
    .en          (en),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_mode    (cfg_mode),
    .clock_out   (clock_out),
    .tick        (tick),
    .cfg_pending (cfg_pending)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Advance one edge; inputs and samples are taken 1ns after it.
  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [CNT_W-1:0] div, input logic mode);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_div  = div;
    cfg_mode = mode;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    step();
    step();
    n_tests++;
    if (clock_out !== 3'b000) begin n_fail++; $display("FAIL reset_clk got=%b exp=000", clock_out); end
    n_tests++;
    if (tick !== 3'b000) begin n_fail++; $display("FAIL reset_tick got=%b exp=000", tick); end
    n_tests++;
    if (cfg_pending !== 3'b000) begin n_fail++; $display("FAIL reset_pend got=%b exp=000", cfg_pending); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_default_div();
    logic exp;
    en = 3'b001;
    for (int k = 0; k < 8; k++) begin
      step();
      exp = (k % 2 == 0);
      n_tests++;
      if (clock_out[0] !== exp) begin n_fail++; $display("FAIL default_clk k=%0d got=%b exp=%b", k, clock_out[0], exp); end
      n_tests++;
      if (tick[0] !== exp) begin n_fail++; $display("FAIL default_tick k=%0d got=%b exp=%b", k, tick[0], exp); end
    end
    en = 3'b000;
    step();
    n_tests++;
    if (clock_out !== 3'b000) begin n_fail++; $display("FAIL disable_clk got=%b exp=000", clock_out); end
  endtask

  task automatic test_square5();
    cfg_write(2'd1, 16'd5, 1'b0);
    n_tests++;
    if (cfg_pending !== 3'b010) begin n_fail++; $display("FAIL sq5_pend_set got=%b exp=010", cfg_pending); end
    step();
    n_tests++;
    if (cfg_pending !== 3'b000) begin n_fail++; $display("FAIL sq5_pend_idle_apply got=%b exp=000", cfg_pending); end
    en = 3'b010;
    for (int k = 0; k < 15; k++) begin
      step();
      n_tests++;
      if (clock_out[1] !== ((k % 5) < 3)) begin
        n_fail++; $display("FAIL sq5_clk k=%0d got=%b exp=%b", k, clock_out[1], ((k % 5) < 3));
      end
      n_tests++;
      if (tick[1] !== ((k % 5) == 0)) begin
        n_fail++; $display("FAIL sq5_tick k=%0d got=%b exp=%b", k, tick[1], ((k % 5) == 0));
      end
    end
    en = 3'b000;
    step();
  endtask

  task automatic test_pulse4();
    logic exp;
    cfg_write(2'd2, 16'd4, 1'b1);
    step();
    en = 3'b100;
    for (int k = 0; k < 12; k++) begin
      step();
      exp = ((k % 4) == 0);
      n_tests++;
      if (clock_out[2] !== exp) begin n_fail++; $display("FAIL pulse4_clk k=%0d got=%b exp=%b", k, clock_out[2], exp); end
      n_tests++;
      if (tick[2] !== exp) begin n_fail++; $display("FAIL pulse4_tick k=%0d got=%b exp=%b", k, tick[2], exp); end
    end
    en = 3'b000;
    step();
  endtask

  task automatic test_reconfig();
    logic exp_clk, exp_tick, exp_pend;
    int p;
    cfg_write(2'd0, 16'd6, 1'b0);
    step();
    en = 3'b001;
    for (int k = 0; k < 15; k++) begin
      step();
      if (k == 2) cfg_we = 1'b0;
      if (k < 6) begin
        exp_clk  = (k < 3);
        exp_tick = (k == 0);
        exp_pend = (k >= 2);
      end else begin
        p        = (k - 6) % 3;
        exp_clk  = (p < 2);
        exp_tick = (p == 0);
        exp_pend = 1'b0;
      end
      n_tests++;
      if (clock_out[0] !== exp_clk) begin n_fail++; $display("FAIL reconf_clk k=%0d got=%b exp=%b", k, clock_out[0], exp_clk); end
      n_tests++;
      if (tick[0] !== exp_tick) begin n_fail++; $display("FAIL reconf_tick k=%0d got=%b exp=%b", k, tick[0], exp_tick); end
      n_tests++;
      if (cfg_pending[0] !== exp_pend) begin n_fail++; $display("FAIL reconf_pend k=%0d got=%b exp=%b", k, cfg_pending[0], exp_pend); end
      if (k == 1) begin
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3; cfg_mode = 1'b0;
      end
    end
    en = 3'b000;
    step();
  endtask

  task automatic test_clamp_and_range();
    logic exp;
    cfg_write(2'd1, 16'd0, 1'b0);
    cfg_write(2'd2, 16'd1, 1'b0);
    step();
    en = 3'b110;
    for (int k = 0; k < 6; k++) begin
      step();
      exp = (k % 2 == 0);
      n_tests++;
      if (clock_out[1] !== exp) begin n_fail++; $display("FAIL clamp0_clk k=%0d got=%b exp=%b", k, clock_out[1], exp); end
      n_tests++;
      if (clock_out[2] !== exp) begin n_fail++; $display("FAIL clamp1_clk k=%0d got=%b exp=%b", k, clock_out[2], exp); end
    end
    en = 3'b000;
    step();
    cfg_write(2'd3, 16'd7, 1'b1);
    n_tests++;
    if (cfg_pending !== 3'b000) begin n_fail++; $display("FAIL range_pend got=%b exp=000", cfg_pending); end
    en = 3'b001;
    for (int k = 0; k < 6; k++) begin
      step();
      exp = ((k % 3) < 2);
      n_tests++;
      if (clock_out[0] !== exp) begin n_fail++; $display("FAIL range_ch0_clk k=%0d got=%b exp=%b", k, clock_out[0], exp); end
    end
    en = 3'b000;
    step();
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    cfg_write(2'd2, 16'd4, 1'b1);
    step();
    en = 3'b111;
    step();
    step();
    cfg_write(2'd1, 16'd9, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (clock_out !== 3'b000) begin n_fail++; $display("FAIL midrst_clk got=%b exp=000", clock_out); end
    n_tests++;
    if (tick !== 3'b000) begin n_fail++; $display("FAIL midrst_tick got=%b exp=000", tick); end
    n_tests++;
    if (cfg_pending !== 3'b000) begin n_fail++; $display("FAIL midrst_pend got=%b exp=000", cfg_pending); end
    en = 3'b000;
    step();
    #2;
    rst = 1'b1;
    step();
    en = 3'b111;
    for (int k = 0; k < 6; k++) begin
      step();
      exp = (k % 2 == 0) ? 3'b111 : 3'b000;
      n_tests++;
      if (clock_out !== exp) begin n_fail++; $display("FAIL postrst_clk k=%0d got=%b exp=%b", k, clock_out, exp); end
      n_tests++;
      if (tick !== exp) begin n_fail++; $display("FAIL postrst_tick k=%0d got=%b exp=%b", k, tick, exp); end
    end
    en = 3'b000;
    step();
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_square5();
    test_pulse4();
    test_reconfig();
    test_clamp_and_range();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
